// File: rtl/arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package arb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_e;

  localparam logic       WE_READ   = 1'b0;
  localparam logic       WE_WRITE  = 1'b1;
  localparam logic [3:0] MASK_WORD = 4'b1111;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter. The arbiter uses the slave
// view; the core/memory environment uses the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              i_request;
  logic [ADDR_W-1:0] i_address;
  logic              i_valid;
  logic [DATA_W-1:0] i_r_data;

  logic              d_request;
  logic              d_we_re;
  logic [3:0]        d_mask;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_w_data;
  logic              d_valid;
  logic [DATA_W-1:0] d_r_data;

  logic              mem_request;
  logic              mem_we_re;
  logic [3:0]        mem_masking;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_w_data;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_r_data;

  logic              busy;
  logic              timeout_err;

  modport slave (
    input  i_request, i_address,
    output i_valid, i_r_data,
    input  d_request, d_we_re, d_mask, d_address, d_w_data,
    output d_valid, d_r_data,
    output mem_request, mem_we_re, mem_masking, mem_address, mem_w_data,
    input  mem_valid, mem_r_data,
    output busy, timeout_err
  );

  modport master (
    output i_request, i_address,
    input  i_valid, i_r_data,
    output d_request, d_we_re, d_mask, d_address, d_w_data,
    input  d_valid, d_r_data,
    input  mem_request, mem_we_re, mem_masking, mem_address, mem_w_data,
    output mem_valid, mem_r_data,
    input  busy, timeout_err
  );
endinterface

// File: rtl/arb_sat_counter.sv
// Up-counter that stops at MAX; clear has priority over increment.
module arb_sat_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + 1'b1;
    end
  end

  assign sat = (count == MAX_V);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store requesters: data first,
// with a streak limit protecting fetch and a watchdog for silent memories.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 16
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  arb_state_e        state_q, state_d;
  logic              grant_i, grant_d, done, abort;
  logic              streak_sat, wdog_sat, busy_s;

  logic              mem_request_q;
  logic              mem_we_re_q;
  logic [3:0]        mem_masking_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [DATA_W-1:0] mem_w_data_q;
  logic [DATA_W-1:0] i_r_data_q;
  logic [DATA_W-1:0] d_r_data_q;

  assign busy_s = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Fetch only overtakes a waiting data request once the streak is used up
        if (bus.d_request && !(bus.i_request && streak_sat)) begin
          grant_d = 1'b1;
          state_d = D_BUSY;
        end else if (bus.i_request) begin
          grant_i = 1'b1;
          state_d = I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (bus.mem_valid) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (wdog_sat) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mem_request_q <= 1'b0;
      mem_we_re_q   <= 1'b0;
      mem_masking_q <= '0;
      mem_address_q <= '0;
      mem_w_data_q  <= '0;
      i_r_data_q    <= '0;
      d_r_data_q    <= '0;
    end else begin
      state_q <= state_d;
      if (grant_d) begin
        mem_request_q <= 1'b1;
        mem_we_re_q   <= bus.d_we_re;
        mem_masking_q <= bus.d_mask;
        mem_address_q <= bus.d_address;
        mem_w_data_q  <= bus.d_w_data;
      end else if (grant_i) begin
        mem_request_q <= 1'b1;
        mem_we_re_q   <= WE_READ;
        mem_masking_q <= MASK_WORD;
        mem_address_q <= bus.i_address;
        mem_w_data_q  <= '0;
      end else if (done || abort) begin
        mem_request_q <= 1'b0;
      end
      if (done && state_q == I_BUSY) i_r_data_q <= bus.mem_r_data;
      if (done && state_q == D_BUSY) d_r_data_q <= bus.mem_r_data;
    end
  end

  arb_sat_counter #(.MAX(MAX_D_STREAK)) u_streak (
    .clk (clk),
    .rst (rst),
    .inc (grant_d && bus.i_request),
    .clr (grant_i || (grant_d && !bus.i_request)),
    .sat (streak_sat)
  );

  // Counts busy cycles without a response; saturation marks the abort cycle
  arb_sat_counter #(.MAX(TIMEOUT - 1)) u_wdog (
    .clk (clk),
    .rst (rst),
    .inc (busy_s && !bus.mem_valid),
    .clr (grant_i || grant_d),
    .sat (wdog_sat)
  );

  // Completion is gated by rst so an access dropped by reset never reports
  assign bus.i_valid     = done && (state_q == I_BUSY) && !rst;
  assign bus.d_valid     = done && (state_q == D_BUSY) && !rst;
  assign bus.i_r_data    = bus.i_valid ? bus.mem_r_data : i_r_data_q;
  assign bus.d_r_data    = bus.d_valid ? bus.mem_r_data : d_r_data_q;
  assign bus.timeout_err = abort && !rst;
  assign bus.busy        = busy_s;

  assign bus.mem_request = mem_request_q;
  assign bus.mem_we_re   = mem_we_re_q;
  assign bus.mem_masking = mem_masking_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_w_data  = mem_w_data_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected grants and
// completions, a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_port_arbiter;
  import arb_pkg::*;

  localparam int K_I  = 0;
  localparam int K_D  = 1;
  localparam int K_TO = 2;

  typedef struct {
    logic        we;
    logic [3:0]  mask;
    logic [7:0]  addr;
    logic [31:0] wdata;
    bit          chk_w;
  } grant_t;

  typedef struct {
    int          kind;
    logic [31:0] data;
    bit          chk;
  } evt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(8), .DATA_W(32), .MAX_D_STREAK(4), .TIMEOUT(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  grant_t      gq[$];
  evt_t        vq[$];
  int          total  = 0;
  int          passed = 0;
  logic [31:0] mem [256];
  int          lat     = 1;
  bit          resp_en = 1'b1;
  bit          spur    = 1'b0;
  int          mcnt    = 0;
  logic        mreq_prev = 1'b0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(act === exp, name, act, exp);
  endtask

  task automatic push_grant(input logic we, input logic [3:0] mask, input logic [7:0] addr,
                            input logic [31:0] wdata, input bit chk_w);
    grant_t g;
    g.we = we; g.mask = mask; g.addr = addr; g.wdata = wdata; g.chk_w = chk_w;
    gq.push_back(g);
  endtask

  task automatic push_evt(input int kind, input logic [31:0] data, input bit chk);
    evt_t e;
    e.kind = kind; e.data = data; e.chk = chk;
    vq.push_back(e);
  endtask

  task automatic pop_evt(input int kind, input logic [31:0] data);
    evt_t e;
    if (vq.size() == 0) begin
      check(1'b0, "unexpected completion/abort event", 32'(kind), 32'hFFFF_FFFF);
    end else begin
      e = vq.pop_front();
      check_eq("event kind", 32'(kind), 32'(e.kind));
      if (e.chk) check_eq("event data", data, e.data);
    end
  endtask

  // which: 0 i_valid, 1 d_valid, 2 timeout_err, 3 mem_request, 4 any valid
  task automatic wait_sig(input int which, input int max_cyc, output int n);
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < max_cyc) begin
      @(negedge clk);
      n++;
      case (which)
        0: hit = (bus.i_valid === 1'b1);
        1: hit = (bus.d_valid === 1'b1);
        2: hit = (bus.timeout_err === 1'b1);
        3: hit = (bus.mem_request === 1'b1);
        default: hit = (bus.i_valid === 1'b1) || (bus.d_valid === 1'b1);
      endcase
    end
    if (!hit) check(1'b0, "wait bound expired", 32'(which), 32'(max_cyc));
  endtask

  // Memory model: answers after lat requested cycles, applies masked writes
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_request === 1'b1) begin
        mcnt++;
        if (resp_en && mcnt == lat) begin
          bus.mem_valid  = 1'b1;
          bus.mem_r_data = mem[bus.mem_address];
          if (bus.mem_we_re == WE_WRITE) begin
            for (int b = 0; b < 4; b++)
              if (bus.mem_masking[b]) mem[bus.mem_address][8*b +: 8] = bus.mem_w_data[8*b +: 8];
          end
        end else begin
          bus.mem_valid  = 1'b0;
          bus.mem_r_data = 32'h0;
        end
      end else begin
        mcnt = 0;
        bus.mem_valid  = spur;
        bus.mem_r_data = spur ? 32'hBAD0_BAD0 : 32'h0;
      end
    end
  end

  // Monitor
  initial begin
    grant_t g;
    forever begin
      @(negedge clk);
      if (bus.mem_request === 1'b1 && mreq_prev !== 1'b1) begin
        if (gq.size() == 0) begin
          check(1'b0, "unexpected grant", 32'(bus.mem_address), 32'hFFFF_FFFF);
        end else begin
          g = gq.pop_front();
          check_eq("grant address", 32'(bus.mem_address), 32'(g.addr));
          check_eq("grant we/mask", 32'({bus.mem_we_re, bus.mem_masking}), 32'({g.we, g.mask}));
          if (g.chk_w) check_eq("grant w_data", bus.mem_w_data, g.wdata);
        end
      end
      mreq_prev = bus.mem_request;
      if (bus.i_valid === 1'b1) pop_evt(K_I, bus.i_r_data);
      if (bus.d_valid === 1'b1) pop_evt(K_D, bus.d_r_data);
      if (bus.timeout_err === 1'b1) pop_evt(K_TO, 32'h0);
    end
  end

  initial begin
    #100000;
    $display("FAIL global time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    for (int a = 0; a < 256; a++) mem[a] = 32'h0;
    mem[8'h04] = 32'h0050_0093;
    mem[8'h10] = 32'h1122_3344;
    mem[8'h20] = 32'h1111_2020;
    mem[8'h30] = 32'hD0D0_3030;
    mem[8'h40] = 32'h4040_4040;
    mem[8'h50] = 32'h5050_ABCD;
    mem[8'h60] = 32'h6060_6060;

    bus.i_request = 1'b0; bus.i_address = 8'h0;
    bus.d_request = 1'b0; bus.d_we_re = 1'b0; bus.d_mask = 4'h0;
    bus.d_address = 8'h0; bus.d_w_data = 32'h0;
    bus.mem_valid = 1'b0; bus.mem_r_data = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("reset busy", 32'(bus.busy), 32'h0);
    check_eq("reset mem_request", 32'(bus.mem_request), 32'h0);
    check_eq("reset mem we/mask", 32'({bus.mem_we_re, bus.mem_masking}), 32'h0);
    check_eq("reset mem_address", 32'(bus.mem_address), 32'h0);
    check_eq("reset mem_w_data", bus.mem_w_data, 32'h0);
    check_eq("reset valids/timeout", 32'({bus.i_valid, bus.d_valid, bus.timeout_err}), 32'h0);
    check_eq("reset i_r_data", bus.i_r_data, 32'h0);
    check_eq("reset d_r_data", bus.d_r_data, 32'h0);
    rst = 1'b0;

    // Fetch-only read, memory answers one cycle after mem_request
    lat = 2;
    push_grant(WE_READ, MASK_WORD, 8'h04, 32'h0, 1'b0);
    push_evt(K_I, 32'h0050_0093, 1'b1);
    bus.i_address = 8'h04;
    bus.i_request = 1'b1;
    wait_sig(0, 20, n);
    bus.i_request = 1'b0;
    check_eq("fetch latency", 32'(n), 32'd2);
    @(negedge clk);
    check_eq("fetch i_r_data held", bus.i_r_data, 32'h0050_0093);
    check_eq("fetch bubble busy", 32'(bus.busy), 32'h0);

    // Store then load to the same address, request held across the bubble
    lat = 1;
    push_grant(WE_WRITE, 4'b0011, 8'h10, 32'hDEAD_BEEF, 1'b1);
    push_evt(K_D, 32'h0, 1'b0);
    push_grant(WE_READ, MASK_WORD, 8'h10, 32'hDEAD_BEEF, 1'b1);
    push_evt(K_D, 32'h1122_BEEF, 1'b1);
    bus.d_we_re = WE_WRITE; bus.d_mask = 4'b0011;
    bus.d_address = 8'h10; bus.d_w_data = 32'hDEAD_BEEF;
    bus.d_request = 1'b1;
    wait_sig(1, 20, n);
    bus.d_we_re = WE_READ; bus.d_mask = MASK_WORD;
    @(negedge clk);
    check_eq("store/load bubble busy", 32'(bus.busy), 32'h0);
    wait_sig(1, 20, n);
    check_eq("load right after bubble", 32'(n), 32'd1);
    check_eq("load busy", 32'(bus.busy), 32'h1);
    bus.d_request = 1'b0;
    check_eq("memory after masked store", mem[8'h10], 32'h1122_BEEF);
    @(negedge clk);

    // Both requesters held: D,D,D,D,I,D,D,D,D,I
    bus.d_we_re = WE_READ; bus.d_mask = MASK_WORD;
    bus.d_address = 8'h30; bus.d_w_data = 32'h0;
    bus.i_address = 8'h20;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        push_grant(WE_READ, MASK_WORD, 8'h30, 32'h0, 1'b1);
        push_evt(K_D, 32'hD0D0_3030, 1'b1);
      end
      push_grant(WE_READ, MASK_WORD, 8'h20, 32'h0, 1'b0);
      push_evt(K_I, 32'h1111_2020, 1'b1);
    end
    bus.d_request = 1'b1;
    bus.i_request = 1'b1;
    for (int k = 0; k < 10; k++) wait_sig(4, 20, n);
    bus.d_request = 1'b0;
    bus.i_request = 1'b0;
    @(negedge clk);

    // mem_valid while idle must be ignored
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    check_eq("idle mem_valid ignored", 32'({bus.i_valid, bus.d_valid, bus.busy}), 32'h0);
    @(negedge clk);

    // Watchdog abort, then a retry against a responsive memory
    resp_en = 1'b0;
    bus.d_address = 8'h40;
    push_grant(WE_READ, MASK_WORD, 8'h40, 32'h0, 1'b1);
    push_evt(K_TO, 32'h0, 1'b0);
    bus.d_request = 1'b1;
    wait_sig(2, 40, n);
    bus.d_request = 1'b0;
    check_eq("timeout after TIMEOUT busy cycles", 32'(n), 32'd16);
    @(negedge clk);
    check_eq("after abort mem_request", 32'(bus.mem_request), 32'h0);
    check_eq("after abort busy", 32'(bus.busy), 32'h0);
    resp_en = 1'b1;
    lat = 1;
    push_grant(WE_READ, MASK_WORD, 8'h40, 32'h0, 1'b1);
    push_evt(K_D, 32'h4040_4040, 1'b1);
    bus.d_request = 1'b1;
    wait_sig(1, 20, n);
    bus.d_request = 1'b0;
    check_eq("retry latency", 32'(n), 32'd1);
    @(negedge clk);

    // Response arrives in the watchdog expiry cycle: completion wins
    lat = 16;
    bus.d_address = 8'h50;
    push_grant(WE_READ, MASK_WORD, 8'h50, 32'h0, 1'b1);
    push_evt(K_D, 32'h5050_ABCD, 1'b1);
    bus.d_request = 1'b1;
    wait_sig(1, 40, n);
    bus.d_request = 1'b0;
    check_eq("late completion cycle", 32'(n), 32'd16);
    check_eq("late completion no timeout_err", 32'(bus.timeout_err), 32'h0);
    @(negedge clk);

    // Reset while a D access has mem_valid pending
    lat = 2;
    bus.d_address = 8'h60;
    push_grant(WE_READ, MASK_WORD, 8'h60, 32'h0, 1'b1);
    bus.d_request = 1'b1;
    wait_sig(3, 10, n);
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.d_request = 1'b0;
    bus.i_address = 8'h04;
    bus.i_request = 1'b1;
    push_grant(WE_READ, MASK_WORD, 8'h04, 32'h0, 1'b0);
    push_evt(K_I, 32'h0050_0093, 1'b1);
    @(negedge clk);
    check_eq("no d_valid under reset", 32'(bus.d_valid), 32'h0);
    @(negedge clk);
    check_eq("post-reset mem_request", 32'(bus.mem_request), 32'h0);
    check_eq("post-reset busy", 32'(bus.busy), 32'h0);
    check_eq("post-reset mem_address", 32'(bus.mem_address), 32'h0);
    check_eq("post-reset d_r_data", bus.d_r_data, 32'h0);
    rst = 1'b0;
    wait_sig(0, 20, n);
    bus.i_request = 1'b0;
    check_eq("fetch after reset latency", 32'(n), 32'd2);
    repeat (3) @(negedge clk);

    check_eq("grant queue drained", 32'(gq.size()), 32'h0);
    check_eq("event queue drained", 32'(vq.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
